// File: rtl/taxi_pkg.sv
// taxi_pkg: shared types and constants for the taxi meter blocks.
//   state_t  : trip state machine encoding (IDLE / RUN / HOLD)
//   FARE_W   : fare width, 4 BCD digits
//   FARE_MAX : saturated fare value, 999.9
package taxi_pkg;

  localparam int unsigned FARE_W = 16;
  localparam logic [FARE_W-1:0] FARE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add4.sv
// bcd_add4: combinational 4-digit BCD adder.
//   a, b : BCD operands (digit 0 in [3:0])
//   sum  : BCD sum, 4 digits
//   cout : carry out of the most significant digit
module bcd_add4
  import taxi_pkg::*;
(
  input  logic [FARE_W-1:0] a,
  input  logic [FARE_W-1:0] b,
  output logic [FARE_W-1:0] sum,
  output logic              cout
);

  logic [4:0] dsum;
  logic       carry;

  always_comb begin
    sum   = '0;
    dsum  = '0;
    carry = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      dsum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
      // Digit overflow: +6 skips the six unused codes and leaves the
      // decimal digit in the low nibble.
      if (dsum > 5'd9) begin
        dsum  = dsum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = dsum[3:0];
    end
    cout = carry;
  end

endmodule

// File: rtl/fare_accum.sv
// fare_accum: trip fare accumulator, 4-digit BCD in units of 0.1 yuan.
//   clk, rst_n     : clock, asynchronous active-low reset
//   trip_start     : pulse, load base fare and enter RUN
//   trip_end       : pulse, freeze fare and enter HOLD
//   fare_clr       : pulse, clear fare and return to IDLE
//   dist_fare_tgl  : async toggle, one distance event per level change
//   wait_fare_tgl  : async toggle, one wait-fare event per level change
//   fare_bcd       : running / final fare
//   trip_active    : in RUN
//   fare_hold      : in HOLD
//   fare_sat       : fare saturated at 999.9
module fare_accum
  import taxi_pkg::*;
#(
  parameter logic [15:0] BASE_FARE = 16'h0100,
  parameter int unsigned BASE_KM   = 3,
  parameter logic [15:0] KM_RATE   = 16'h0020,
  parameter logic [15:0] WAIT_RATE = 16'h0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trip_start,
  input  logic              trip_end,
  input  logic              fare_clr,
  input  logic              dist_fare_tgl,
  input  logic              wait_fare_tgl,
  output logic [FARE_W-1:0] fare_bcd,
  output logic              trip_active,
  output logic              fare_hold,
  output logic              fare_sat
);

  localparam int unsigned KM_W = 8;
  localparam logic [KM_W-1:0] KM_BASE = KM_W'(BASE_KM);

  state_t            state, state_n;
  logic [FARE_W-1:0] fare_n;
  logic              sat_n;
  logic [KM_W-1:0]   km_cnt, km_n;
  logic              pend_dist, pend_wait, pd_n, pw_n;
  logic              add_en;

  logic [1:0] dist_sync, wait_sync;
  logic       dist_hist, wait_hist;
  logic       ev_dist, ev_wait;

  logic [FARE_W-1:0] add_b, add_sum;
  logic              add_cout;

  // History FFs follow the toggles in every state, so an edge seen outside
  // RUN is consumed and never turns into a late event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_sync <= '0;
      wait_sync <= '0;
      dist_hist <= 1'b0;
      wait_hist <= 1'b0;
    end else begin
      dist_sync <= {dist_sync[0], dist_fare_tgl};
      wait_sync <= {wait_sync[0], wait_fare_tgl};
      dist_hist <= dist_sync[1];
      wait_hist <= wait_sync[1];
    end
  end

  assign ev_dist = dist_sync[1] ^ dist_hist;
  assign ev_wait = wait_sync[1] ^ wait_hist;

  // Distance is always served first, so the operand follows pend_dist.
  assign add_b = pend_dist ? KM_RATE : WAIT_RATE;

  bcd_add4 u_add (
    .a    (fare_bcd),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fare_bcd  <= '0;
      fare_sat  <= 1'b0;
      km_cnt    <= '0;
      pend_dist <= 1'b0;
      pend_wait <= 1'b0;
    end else begin
      state     <= state_n;
      fare_bcd  <= fare_n;
      fare_sat  <= sat_n;
      km_cnt    <= km_n;
      pend_dist <= pd_n;
      pend_wait <= pw_n;
    end
  end

  always_comb begin
    state_n = state;
    fare_n  = fare_bcd;
    sat_n   = fare_sat;
    km_n    = km_cnt;
    pd_n    = pend_dist;
    pw_n    = pend_wait;
    add_en  = 1'b0;
    if (fare_clr) begin
      state_n = ST_IDLE;
      fare_n  = '0;
      sat_n   = 1'b0;
      km_n    = '0;
      pd_n    = 1'b0;
      pw_n    = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (trip_start) begin
            state_n = ST_RUN;
            fare_n  = BASE_FARE;
            sat_n   = 1'b0;
            km_n    = '0;
            pd_n    = 1'b0;
            pw_n    = 1'b0;
          end
        end
        ST_RUN: begin
          if (trip_end) begin
            state_n = ST_HOLD;
            pd_n    = 1'b0;
            pw_n    = 1'b0;
          end else begin
            if (pend_dist) begin
              pd_n = 1'b0;
              if (km_cnt < KM_BASE) km_n = km_cnt + KM_W'(1);
              else                  add_en = !fare_sat;
            end else if (pend_wait) begin
              pw_n   = 1'b0;
              add_en = !fare_sat;
            end
            if (add_en) begin
              if (add_cout) begin
                fare_n = FARE_MAX;
                sat_n  = 1'b1;
              end else begin
                fare_n = add_sum;
              end
            end
            // A same-type event while its flag is still set is dropped.
            if (ev_dist && !pend_dist) pd_n = 1'b1;
            if (ev_wait && !pend_wait) pw_n = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign trip_active = (state == ST_RUN);
  assign fare_hold   = (state == ST_HOLD);

endmodule

// File: tb/tb_fare_accum.sv
`timescale 1ns/100ps
module tb_fare_accum;

  typedef struct {
    string       tag;
    int unsigned cyc;
    logic [15:0] fare;
    logic        act;
    logic        hold;
    logic        sat;
  } exp_t;

  logic clk;
  logic rst_n;
  logic start, tend, clr, dtgl, wtgl;
  logic s_start, s_end, s_clr, s_dtgl, s_wtgl;
  logic [15:0] fare0, fare1;
  logic act0, hold0, sat0, act1, hold1, sat1;

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [18:0] prev0 = '0;
  logic [18:0] prev1 = '0;

  fare_accum #(
    .BASE_FARE (16'h0100),
    .BASE_KM   (3),
    .KM_RATE   (16'h0020),
    .WAIT_RATE (16'h0010)
  ) u_dut (
    .clk (clk), .rst_n (rst_n),
    .trip_start (start), .trip_end (tend), .fare_clr (clr),
    .dist_fare_tgl (dtgl), .wait_fare_tgl (wtgl),
    .fare_bcd (fare0), .trip_active (act0), .fare_hold (hold0), .fare_sat (sat0)
  );

  fare_accum #(
    .WAIT_RATE (16'h5000)
  ) u_sat (
    .clk (clk), .rst_n (rst_n),
    .trip_start (s_start), .trip_end (s_end), .fare_clr (s_clr),
    .dist_fare_tgl (s_dtgl), .wait_fare_tgl (s_wtgl),
    .fare_bcd (fare1), .trip_active (act1), .fare_hold (hold1), .fare_sat (sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", tag, got, req);
    end
  endtask

  task automatic on_change(input int id, input logic [18:0] cur);
    exp_t e;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_change dut%0d cyc=%0d got=%h required=no change", id, cyc, cur);
    end else begin
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      chk($sformatf("%s_value", e.tag), cur, {e.fare, e.act, e.hold, e.sat});
      total++;
      if (cyc != e.cyc) begin
        bad++;
        $display("FAIL %s_cycle got=%0d required=%0d", e.tag, cyc, e.cyc);
      end
    end
  endtask

  // Monitor: every visible change of a DUT's outputs consumes one expectation.
  always @(negedge clk) begin
    logic [18:0] c0, c1;
    c0 = {fare0, act0, hold0, sat0};
    c1 = {fare1, act1, hold1, sat1};
    if (c0 !== prev0) begin on_change(0, c0); prev0 = c0; end
    if (c1 !== prev1) begin on_change(1, c1); prev1 = c1; end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic exp0(input string tag, input int unsigned dc, input logic [15:0] f,
                      input logic a, input logic h, input logic s);
    exp_t e;
    e.tag = tag; e.cyc = cyc + dc; e.fare = f; e.act = a; e.hold = h; e.sat = s;
    q0.push_back(e);
  endtask

  task automatic exp1(input string tag, input int unsigned dc, input logic [15:0] f,
                      input logic a, input logic h, input logic s);
    exp_t e;
    e.tag = tag; e.cyc = cyc + dc; e.fare = f; e.act = a; e.hold = h; e.sat = s;
    q1.push_back(e);
  endtask

  logic [15:0] dist_fares [5] = '{16'h0100, 16'h0100, 16'h0100, 16'h0120, 16'h0140};

  initial begin
    rst_n = 1'b0;
    {start, tend, clr, dtgl, wtgl} = '0;
    {s_start, s_end, s_clr, s_dtgl, s_wtgl} = '0;
    #23 rst_n = 1'b1;
    chk("reset_dut0", {fare0, act0, hold0, sat0}, '0);
    chk("reset_dut1", {fare1, act1, hold1, sat1}, '0);
    idle(2);

    // Base load
    start = 1'b1; exp0("start", 1, 16'h0100, 1, 0, 0); tick(); start = 1'b0;
    idle(5);

    // Distance: first BASE_KM events are absorbed
    for (int i = 0; i < 5; i++) begin
      dtgl = ~dtgl;
      if (i >= 3) exp0($sformatf("dist%0d", i), 4, dist_fares[i], 1, 0, 0);
      idle(10);
    end

    // Simultaneous distance + wait
    dtgl = ~dtgl; wtgl = ~wtgl;
    exp0("sim_dist", 4, 16'h0160, 1, 0, 0);
    exp0("sim_wait", 5, 16'h0170, 1, 0, 0);
    idle(10);

    // Trip end, toggles in HOLD ignored
    tend = 1'b1; exp0("end", 1, 16'h0170, 0, 1, 0); tick(); tend = 1'b0;
    idle(3);
    dtgl = ~dtgl; idle(5);
    wtgl = ~wtgl; idle(10);

    // Restart: nothing late, km count restarts
    start = 1'b1; exp0("restart", 1, 16'h0100, 1, 0, 0); tick(); start = 1'b0;
    idle(10);
    dtgl = ~dtgl; idle(10);
    wtgl = ~wtgl; exp0("wait_after_restart", 4, 16'h0110, 1, 0, 0); idle(10);

    // Clear
    clr = 1'b1; exp0("clr", 1, 16'h0000, 0, 0, 0); tick(); clr = 1'b0;
    idle(5);

    // fare_clr beats trip_end
    start = 1'b1; exp0("start2", 1, 16'h0100, 1, 0, 0); tick(); start = 1'b0;
    idle(3);
    tend = 1'b1; clr = 1'b1; exp0("clr_over_end", 1, 16'h0000, 0, 0, 0); tick();
    tend = 1'b0; clr = 1'b0;
    idle(5);

    // Saturation on the WAIT_RATE=5000 instance
    s_start = 1'b1; exp1("sat_start", 1, 16'h0100, 1, 0, 0); tick(); s_start = 1'b0;
    idle(5);
    s_wtgl = ~s_wtgl; exp1("sat_5100", 4, 16'h5100, 1, 0, 0); idle(10);
    s_wtgl = ~s_wtgl; exp1("sat_9999", 4, 16'h9999, 1, 0, 1); idle(10);
    s_wtgl = ~s_wtgl; idle(10);
    s_end = 1'b1; exp1("sat_end", 1, 16'h9999, 0, 1, 1); tick(); s_end = 1'b0;
    idle(3);
    s_start = 1'b1; exp1("sat_restart", 1, 16'h0100, 1, 0, 0); tick(); s_start = 1'b0;
    idle(3);
    s_clr = 1'b1; exp1("sat_clr", 1, 16'h0000, 0, 0, 0); tick(); s_clr = 1'b0;
    idle(5);

    // Async reset with a wait event pending
    start = 1'b1; exp0("start3", 1, 16'h0100, 1, 0, 0); tick(); start = 1'b0;
    idle(5);
    wtgl = ~wtgl;
    idle(3);
    #2;
    rst_n = 1'b0;
    exp0("async_reset", 0, 16'h0000, 0, 0, 0);
    #0.5;
    chk("async_reset_now", {fare0, act0, hold0, sat0}, '0);
    #2.5 rst_n = 1'b1;
    idle(12);

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d outstanding required=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fare_accum.md
# fare_accum

Trip fare accumulator downstream of the distance and waiting-time counters. It consumes the toggle-encoded wait-fare and distance-fare events and maintains the running fare as 4-digit BCD in units of 0.1 yuan (000.0–999.9). A trip state machine controls the accumulator, and the accumulator's output drives the display/segment driver.

## Interface
- `BASE_FARE`, default 16'h0100 (BCD 010.0): fare loaded at trip start.
- `BASE_KM`, default 3: number of distance events absorbed by the base fare.
- `KM_RATE`, default 16'h0020 (BCD 002.0): increment per distance event beyond `BASE_KM`.
- `WAIT_RATE`, default 16'h0010 (BCD 001.0): increment per wait-fare event.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `trip_start` in 1: single-cycle pulse, synchronous to `clk`.
- `trip_end` in 1: single-cycle pulse, synchronous to `clk`.
- `fare_clr` in 1: single-cycle pulse, synchronous to `clk`; returns the block to idle.
- `dist_fare_tgl` in 1: asynchronous. Each level change is one distance event.
- `wait_fare_tgl` in 1: asynchronous. Each level change is one wait-fare event. This is the wait-count stage output.
- `fare_bcd` out 16: running or final fare, 4 BCD digits, LSD = 0.1 yuan.
- `trip_active` out 1: high in RUN.
- `fare_hold` out 1: high in HOLD (final fare shown).
- `fare_sat` out 1: fare has saturated at 999.9.

## Operation
- **Reset values:** state IDLE, `fare_bcd`=0, all flags 0, sync chains 0, `km_cnt`=0, pending flags 0.
- **Toggle inputs:** each passes a 2-FF synchronizer plus one history FF. An event is (sync2 XOR hist). The history FFs track the toggle in every state, so an edge that arrives outside RUN never becomes a late event.
- **FSM states:** IDLE, RUN, HOLD.
  - IDLE + `trip_start` → RUN. Load `fare_bcd`=`BASE_FARE`, `km_cnt`=0, clear pending flags and `fare_sat`.
  - RUN + `trip_end` → HOLD. Freeze the fare and drop pending events.
  - HOLD + `trip_start` → RUN with the same load as from IDLE.
  - Any state + `fare_clr` → IDLE. Set `fare_bcd`=0 and `fare_sat`=0.
  - **Priority:** `fare_clr` > `trip_end` > `trip_start`. `trip_start` in RUN is ignored.
- **Events in RUN:**
  - Detected events set `pend_dist` / `pend_wait`.
  - One addition per cycle. Distance has priority; wait is served the next cycle.
  - A pending flag clears when its addition is served.
  - A new event of the same type arriving while its flag is still set is not queued. It is impossible at legal input rates (at most one toggle per 4 clk).
- **Distance event:** if `km_cnt` < `BASE_KM`, increment `km_cnt` and add nothing. Otherwise add `KM_RATE`. `km_cnt` saturates at `BASE_KM`.
- **Wait event:** add `WAIT_RATE`.
- **Arithmetic:** 4-digit BCD add with per-digit +6 correction. If the carry out of the MSD is 1, force `fare_bcd`=16'h9999 and set `fare_sat`. Once saturated, further additions are ignored until the next trip start or clear.
- **Events outside RUN:** discarded (pending flags are not set).

## Timing
- **Event latency:** a toggle edge sampled at clk edge N produces the updated `fare_bcd` at edge N+3 (sync1 N, sync2 N+1, pending set N+2, fare N+3).
  - If both types are pending in the same cycle: distance result at N+3, wait result at N+4.
- **Control latency:** `trip_start`, `trip_end` and `fare_clr` take effect at the next clk edge. Outputs are registered, with no combinational path from input to output.
- **Simultaneous control and events:**
  - `trip_end` in the same cycle as a served addition: the addition is dropped and the fare freezes at its prior value.
  - `trip_start` in the same cycle as an event: the load wins and the event is dropped.
- **Reset mid-trip:** immediate return to the reset values above. Syncs restart, so the first post-reset edge is detected normally.

## Structure
- **Shared package `taxi_pkg`:**
  - state encoding localparams `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_HOLD`=2'd2
  - `FARE_W`=16
  - `FARE_MAX`=16'h9999
- **Sub-module `bcd_add4`:** combinational, inputs a[15:0], b[15:0], output sum[15:0] and cout. Reused by the display/receipt logic.
- **Synchronizer + edge detect:** written inline, two instances.

## Test plan
- **Reset and base load:** reset, then `trip_start` → `fare_bcd`=0100, `trip_active`=1 one cycle later. Before that: all outputs 0.
- **Distance fares:** 5 `dist_fare_tgl` toggles spaced 10 clk → fare 0100 for the first 3, then 0120 and 0140. Each update lands exactly 3 clk after the sampled edge.
- **Simultaneous events:** `dist_fare_tgl` and `wait_fare_tgl` toggle in the same cycle, after `BASE_KM` is consumed, starting from 0140 → 0160 at N+3, 0170 at N+4.
- **Saturation:** `WAIT_RATE`=16'h5000. Starting at base, events take the fare to 5100, then 9999 with `fare_sat`=1. A further event leaves 9999.
- **Trip end and restart:** `trip_end` → `fare_hold`=1. Toggles in HOLD leave the fare unchanged and are not applied after restart. `trip_start` → 0100. `fare_clr` → 0000, IDLE.
- **Async reset mid-trip:** assert `rst_n` low between clk edges with a pending event → outputs 0 immediately. No addition after release.
